link_sync_ctrl: RTL

Receive-side link synchronisation controller placed after the serial-to-parallel converter in the PHY receive path, in the clk_4f domain. It monitors the recovered byte stream for COM (8'hBC) and IDL (8'h7C) control characters and code errors, and runs the acquire/lose-sync state machine. It qualifies downstream data: asserts idle when the link is synced and idling, and forwards data bytes only while synced.

---
 rtl/link_pkg.sv | 19 +
 rtl/link_err_monitor.sv | 60 ++++++
 rtl/link_sync_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/link_pkg.sv
// ---------------------------------------------------------------------------
// link_pkg
// Shared definitions for the receive-side link synchronisation controller:
// FSM state encoding, control character codes and the counter width.
// ---------------------------------------------------------------------------
package link_pkg;

  localparam int         CNT_W = 4;
  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_IDL = 8'h7C;

  // 2'd3 is unused; the FSM treats it as illegal and falls back to LOS.
  typedef enum logic [1:0] {
    LOS       = 2'd0,
    COMMA_DET = 2'd1,
    SYNC      = 2'd2
  } link_state_e;

endpackage

// File: rtl/link_err_monitor.sv
// ---------------------------------------------------------------------------
// link_err_monitor
// Tracks code-error density while the link is in SYNC. Bad bytes add to an
// accumulated bad count; every GOOD_RUN consecutive good bytes remove one.
// When the accumulated count reaches BAD_MAX, o_lose_sync pulses in the
// same cycle as the offending byte and both counters clear.
//
// Ports:
//   clk_4f      - byte clock
//   reset_L     - asynchronous active-low reset
//   i_clear     - clear both counters (sync just acquired)
//   i_bad       - bad byte received while in SYNC
//   i_good      - good byte received while in SYNC
//   o_lose_sync - combinational pulse: this bad byte reaches BAD_MAX
// ---------------------------------------------------------------------------
module link_err_monitor
  import link_pkg::*;
#(
  parameter int BAD_MAX  = 4,
  parameter int GOOD_RUN = 4
) (
  input  logic clk_4f,
  input  logic reset_L,
  input  logic i_clear,
  input  logic i_bad,
  input  logic i_good,
  output logic o_lose_sync
);

  logic [CNT_W-1:0] r_bad_cnt;
  logic [CNT_W-1:0] r_good_cnt;
  logic [CNT_W-1:0] w_bad_inc;
  logic [CNT_W-1:0] w_good_inc;

  assign w_bad_inc   = r_bad_cnt + CNT_W'(1);
  assign w_good_inc  = r_good_cnt + CNT_W'(1);
  assign o_lose_sync = i_bad && (w_bad_inc == CNT_W'(BAD_MAX));

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      r_bad_cnt  <= '0;
      r_good_cnt <= '0;
    end else if (i_clear || o_lose_sync) begin
      r_bad_cnt  <= '0;
      r_good_cnt <= '0;
    end else if (i_bad) begin
      r_bad_cnt  <= w_bad_inc;
      r_good_cnt <= '0;
    end else if (i_good && (r_bad_cnt != '0)) begin
      // A full run of good bytes forgives one earlier error.
      if (w_good_inc == CNT_W'(GOOD_RUN)) begin
        r_bad_cnt  <= r_bad_cnt - CNT_W'(1);
        r_good_cnt <= '0;
      end else begin
        r_good_cnt <= w_good_inc;
      end
    end
  end

endmodule

// File: rtl/link_sync_ctrl.sv
// ---------------------------------------------------------------------------
// link_sync_ctrl
// Receive-side link synchronisation controller (clk_4f domain). Searches the
// recovered byte stream for COM_THRESH consecutive good COM characters to
// acquire sync, drops sync once BAD_MAX bad bytes accumulate, and qualifies
// downstream data: flags idle on IDL and forwards data bytes while synced.
//
// Optional build macro: LINK_SYNC_EVT_CNT_EN
//   defined   - err_events counts SYNC->LOS transitions, saturating at FFFF
//   undefined - err_events is tied to zero
//
// Ports:
//   clk_4f      - byte clock, all state on rising edge
//   reset_L     - asynchronous active-low reset
//   rx_byte     - parallel byte from the deserialiser
//   rx_vld      - rx_byte valid; invalid cycles are ignored
//   rx_code_err - code violation on the current byte
//   sync_ok     - link synchronised (state == SYNC)
//   idle_out    - synced and idling
//   data_out    - last forwarded data byte
//   valid_out   - one-cycle strobe per forwarded byte
//   state_out   - FSM state, debug
//   err_events  - loss-of-sync event counter
// ---------------------------------------------------------------------------
module link_sync_ctrl
  import link_pkg::*;
#(
  parameter int COM_THRESH = 4,
  parameter int BAD_MAX    = 4,
  parameter int GOOD_RUN   = 4
) (
  input  logic        clk_4f,
  input  logic        reset_L,
  input  logic [7:0]  rx_byte,
  input  logic        rx_vld,
  input  logic        rx_code_err,
  output logic        sync_ok,
  output logic        idle_out,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic [1:0]  state_out,
  output logic [15:0] err_events
);

  link_state_e      r_state;
  link_state_e      w_state_nxt;
  logic [CNT_W-1:0] r_com_cnt;
  logic [CNT_W-1:0] w_com_nxt;
  logic [CNT_W-1:0] w_com_inc;
  logic             w_acquire;
  logic             w_lose_sync;
  logic             w_good;
  logic             w_bad;
  logic             w_is_com;
  logic             w_is_idl;
  logic             w_in_sync;
  logic             r_idle;
  logic             r_valid;
  logic [7:0]       r_data;

  assign w_good    = rx_vld && !rx_code_err;
  assign w_bad     = rx_vld && rx_code_err;
  assign w_is_com  = (rx_byte == K_COM);
  assign w_is_idl  = (rx_byte == K_IDL);
  assign w_in_sync = (r_state == SYNC);
  assign w_com_inc = r_com_cnt + CNT_W'(1);

  link_err_monitor #(
    .BAD_MAX  (BAD_MAX),
    .GOOD_RUN (GOOD_RUN)
  ) u_err_mon (
    .clk_4f      (clk_4f),
    .reset_L     (reset_L),
    .i_clear     (w_acquire),
    .i_bad       (w_bad && w_in_sync),
    .i_good      (w_good && w_in_sync),
    .o_lose_sync (w_lose_sync)
  );

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      r_state   <= LOS;
      r_com_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_com_cnt <= w_com_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_com_nxt   = r_com_cnt;
    w_acquire   = 1'b0;
    case (r_state)
      LOS: begin
        if (w_good && w_is_com) begin
          w_state_nxt = COMMA_DET;
          w_com_nxt   = CNT_W'(1);
        end
      end
      COMMA_DET: begin
        if (w_good && w_is_com) begin
          if (w_com_inc == CNT_W'(COM_THRESH)) begin
            w_state_nxt = SYNC;
            w_com_nxt   = '0;
            w_acquire   = 1'b1;
          end else begin
            w_com_nxt = w_com_inc;
          end
        end else if (rx_vld) begin
          // Any other accepted byte breaks the COM run.
          w_state_nxt = LOS;
          w_com_nxt   = '0;
        end
      end
      SYNC: begin
        if (w_lose_sync) begin
          w_state_nxt = LOS;
          w_com_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = LOS;
        w_com_nxt   = '0;
      end
    endcase
  end

  // Output qualification. Idle is only meaningful while staying in SYNC, so
  // it drops in the same cycle the FSM leaves SYNC (including on the bad byte
  // that triggers loss of sync).
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      r_idle  <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= 8'h00;
    end else begin
      r_valid <= 1'b0;
      if (w_state_nxt != SYNC) begin
        r_idle <= 1'b0;
      end else if (w_in_sync && w_good) begin
        if (w_is_idl) begin
          r_idle <= 1'b1;
        end else if (!w_is_com) begin
          r_idle  <= 1'b0;
          r_valid <= 1'b1;
          r_data  <= rx_byte;
        end
      end
    end
  end

  assign sync_ok   = w_in_sync;
  assign idle_out  = r_idle;
  assign valid_out = r_valid;
  assign data_out  = r_data;
  assign state_out = r_state;

`ifdef LINK_SYNC_EVT_CNT_EN
  logic [15:0] r_err_events;

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      r_err_events <= 16'h0000;
    end else if (w_lose_sync && (r_err_events != 16'hFFFF)) begin
      r_err_events <= r_err_events + 16'd1;
    end
  end

  assign err_events = r_err_events;
`else
  assign err_events = 16'h0000;
`endif

endmodule
